pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder_if.sv | 32 +++
 rtl/pipe_adder.sv | 134 +++++++++++++
 tb/tb_pipe_adder.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_adder_if.sv
// pipe_adder_if -- handshake and data bundle for pipe_adder.
//
// Upstream side : s_valid, s_ready, A, B, ci
// Downstream side: m_valid, m_ready, S, co, ovf
//
// Modports:
//   master -- the environment that feeds operands and consumes results
//   slave  -- the adder itself
interface pipe_adder_if #(
  parameter int N = 8
);
  logic         s_valid;
  logic         s_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         ci;
  logic         m_valid;
  logic         m_ready;
  logic [N-1:0] S;
  logic         co;
  logic         ovf;

  modport master (
    output s_valid, A, B, ci, m_ready,
    input  s_ready, m_valid, S, co, ovf
  );

  modport slave (
    input  s_valid, A, B, ci, m_ready,
    output s_ready, m_valid, S, co, ovf
  );
endinterface

// File: rtl/pipe_adder.sv
// pipe_adder -- pipelined N-bit signed adder with valid/ready flow control.
//
// The N-bit add is split into STAGES slices of W = N/STAGES bits. Stage k
// adds slice k of A and B plus the carry registered by stage k-1 (ci for
// stage 0). Operand slices not yet consumed and sum slices already produced
// travel with their transaction, so every output field belongs to one
// operand set. The last stage register is the output register.
//
// Ports:
//   clk   -- rising-edge clock
//   rstn  -- asynchronous active-low reset
//   bus   -- pipe_adder_if.slave: s_valid/s_ready/A/B/ci in,
//            m_valid/m_ready/S/co/ovf out
//
// Parameters: N (width, >= 2), STAGES (1..N, N % STAGES == 0).
//
// Optional feature: define PIPE_ADDER_SAT_EN to saturate S on signed
// overflow (co and ovf always report the raw add).
module pipe_adder #(
  parameter int N      = 8,
  parameter int STAGES = 2
) (
  input  logic          clk,
  input  logic          rstn,
  pipe_adder_if.slave   bus
);

  localparam int W = N / STAGES;

  // Whole pipe moves together; it may move whenever the output register is
  // empty or being drained this cycle.
  logic adv;
  assign adv         = bus.m_ready || !bus.m_valid;
  assign bus.s_ready = adv;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : stg
      localparam int RW = N - gi * W;    // operand bits still to be added
      localparam int SW = (gi + 1) * W;  // sum bits complete after this stage

      logic          v_in;
      logic          c_in;
      logic [RW-1:0] a_rem;
      logic [RW-1:0] b_rem;
      logic [W:0]    part;
      logic [SW-1:0] s_next;
      logic [SW-1:0] s_store;
      logic          v_reg;
      logic          c_reg;
      logic [SW-1:0] s_reg;

      if (gi == 0) begin : src
        assign v_in   = bus.s_valid;
        assign c_in   = bus.ci;
        assign a_rem  = bus.A;
        assign b_rem  = bus.B;
        assign s_next = part[W-1:0];
      end else begin : src
        assign v_in   = stg[gi-1].v_reg;
        assign c_in   = stg[gi-1].c_reg;
        assign a_rem  = stg[gi-1].mid.a_hi_reg;
        assign b_rem  = stg[gi-1].mid.b_hi_reg;
        assign s_next = {part[W-1:0], stg[gi-1].s_reg};
      end

      assign part = {1'b0, a_rem[W-1:0]} + {1'b0, b_rem[W-1:0]} + {{W{1'b0}}, c_in};

      if (gi < STAGES - 1) begin : mid
        // Upper operand slices carried forward for the following stages.
        logic [RW-W-1:0] a_hi_reg;
        logic [RW-W-1:0] b_hi_reg;

        assign s_store = s_next;

        always_ff @(posedge clk or negedge rstn) begin
          if (!rstn) begin
            a_hi_reg <= '0;
            b_hi_reg <= '0;
          end else if (adv) begin
            a_hi_reg <= a_rem[RW-1:W];
            b_hi_reg <= b_rem[RW-1:W];
          end
        end
      end else begin : fin
        logic ovf_next;
        logic ovf_reg;

        // a_rem[W-1]/b_rem[W-1] are the operand sign bits. Their XOR with the
        // sum MSB recovers the carry into bit N-1; XOR with the carry out of
        // bit N-1 gives signed overflow.
        assign ovf_next = (a_rem[W-1] ^ b_rem[W-1] ^ part[W-1]) ^ part[W];

`ifdef PIPE_ADDER_SAT_EN
        // Overflow only happens with equal operand signs, so A's sign picks
        // the saturation direction.
        assign s_store = ovf_next ? (a_rem[W-1] ? {1'b1, {(N-1){1'b0}}}
                                                : {1'b0, {(N-1){1'b1}}})
                                  : s_next;
`else
        assign s_store = s_next;
`endif

        always_ff @(posedge clk or negedge rstn) begin
          if (!rstn) begin
            ovf_reg <= 1'b0;
          end else if (adv) begin
            ovf_reg <= ovf_next;
          end
        end
      end

      // Bubbles shift through like real entries (valid bit low); nothing is
      // compressed while the pipe is held.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          v_reg <= 1'b0;
          c_reg <= 1'b0;
          s_reg <= '0;
        end else if (adv) begin
          v_reg <= v_in;
          c_reg <= part[W];
          s_reg <= s_store;
        end
      end
    end
  endgenerate

  assign bus.m_valid = stg[STAGES-1].v_reg;
  assign bus.S       = stg[STAGES-1].s_reg;
  assign bus.co      = stg[STAGES-1].c_reg;
  assign bus.ovf     = stg[STAGES-1].fin.ovf_reg;

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder -- self-checking bench for pipe_adder (N=8, STAGES=2).
// Inputs are driven on the falling edge and outputs sampled 1 time unit
// later, so every check sees settled values away from the rising edge.
module tb_pipe_adder;
  localparam int N      = 8;
  localparam int STAGES = 2;

  typedef logic [N+1:0] res_t;  // {co, ovf, S}

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  pipe_adder_if #(.N(N)) bus ();

  pipe_adder #(.N(N), .STAGES(STAGES)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  res_t exp_q[$];

  // Reference: plain integer arithmetic on the operand values.
  function automatic res_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
    int          us;
    int          ss;
    logic        v;
    logic        co_m;
    logic [N-1:0] s;
    us   = int'(a) + int'(b) + int'(c);
    co_m = (us >= (1 << N));
    s    = us[N-1:0];
    ss   = int'($signed(a)) + int'($signed(b)) + int'(c);
    v    = (ss > (1 << (N-1)) - 1) || (ss < -(1 << (N-1)));
`ifdef PIPE_ADDER_SAT_EN
    if (v) s = (ss > 0) ? {1'b0, {(N-1){1'b1}}} : {1'b1, {(N-1){1'b0}}};
`endif
    return {co_m, v, s};
  endfunction

  function automatic res_t observed();
    return {bus.co, bus.ovf, bus.S};
  endfunction

  task automatic idle_inputs();
    bus.s_valid = 1'b0;
    bus.A       = '0;
    bus.B       = '0;
    bus.ci      = 1'b0;
    bus.m_ready = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.m_ready = 1'b0;
    #2 rstn = 1'b0;
    #1;
    n_checks++; if (bus.m_valid !== 1'b0) $display("FAIL rst_m_valid: got %b expected 0", bus.m_valid); else n_pass++;
    n_checks++; if (bus.S !== '0) $display("FAIL rst_S: got %h expected 00", bus.S); else n_pass++;
    n_checks++; if ({bus.co, bus.ovf} !== 2'b00) $display("FAIL rst_co_ovf: got %b expected 00", {bus.co, bus.ovf}); else n_pass++;
    n_checks++; if (bus.s_ready !== 1'b1) $display("FAIL rst_s_ready: got %b expected 1", bus.s_ready); else n_pass++;
    @(negedge clk);
    rstn        = 1'b1;
    bus.m_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_latency();
    @(negedge clk);
    bus.A = 8'd5; bus.B = 8'd10; bus.ci = 1'b0; bus.s_valid = 1'b1; bus.m_ready = 1'b1;
    #1;
    n_checks++; if (bus.s_ready !== 1'b1) $display("FAIL lat_s_ready: got %b expected 1", bus.s_ready); else n_pass++;
    @(negedge clk);
    bus.s_valid = 1'b0;
    #1;
    n_checks++; if (bus.m_valid !== 1'b0) $display("FAIL lat_edge1_valid: got %b expected 0", bus.m_valid); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (bus.m_valid !== 1'b1) $display("FAIL lat_edge2_valid: got %b expected 1", bus.m_valid); else n_pass++;
    n_checks++;
    if (observed() !== {1'b0, 1'b0, 8'd15}) $display("FAIL lat_result: got %h expected %h", observed(), {1'b0, 1'b0, 8'd15});
    else n_pass++;
    $display("tx latency: A=5 B=10 ci=0 -> S=%0d co=%b ovf=%b", bus.S, bus.co, bus.ovf);
    @(negedge clk); #1;
    n_checks++; if (bus.m_valid !== 1'b0) $display("FAIL lat_one_cycle: got %b expected 0", bus.m_valid); else n_pass++;
  endtask

  task automatic test_directed();
    logic [N-1:0] da[6] = '{8'h0F, 8'h1E, 8'h7F, 8'h80, 8'hFF, 8'h7F};
    logic [N-1:0] db[6] = '{8'h01, 8'hF6, 8'h01, 8'hFF, 8'h00, 8'h7F};
    logic         dc[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`ifdef PIPE_ADDER_SAT_EN
    res_t de[6] = '{{2'b00, 8'h10}, {2'b10, 8'h14}, {2'b01, 8'h7F},
                    {2'b11, 8'h80}, {2'b10, 8'h00}, {2'b01, 8'h7F}};
`else
    res_t de[6] = '{{2'b00, 8'h10}, {2'b10, 8'h14}, {2'b01, 8'h80},
                    {2'b11, 8'h7F}, {2'b10, 8'h00}, {2'b01, 8'hFF}};
`endif
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.A = da[i]; bus.B = db[i]; bus.ci = dc[i]; bus.s_valid = 1'b1; bus.m_ready = 1'b1;
      @(negedge clk);
      bus.s_valid = 1'b0;
      @(negedge clk); #1;
      n_checks++;
      if (bus.m_valid !== 1'b1 || observed() !== de[i])
        $display("FAIL directed_%0d: got v=%b %h expected v=1 %h", i, bus.m_valid, observed(), de[i]);
      else n_pass++;
      $display("tx directed %0d: A=%h B=%h ci=%b -> S=%h co=%b ovf=%b", i, da[i], db[i], dc[i], bus.S, bus.co, bus.ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    res_t exp_r[6];
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      bus.m_ready = 1'b1;
      if (c < 6) begin
        bus.A = N'($urandom()); bus.B = N'($urandom()); bus.ci = 1'($urandom_range(0, 1));
        bus.s_valid = 1'b1;
        exp_r[c] = model(bus.A, bus.B, bus.ci);
      end else begin
        bus.s_valid = 1'b0;
      end
      #1;
      n_checks++; if (bus.s_ready !== 1'b1) $display("FAIL b2b_s_ready_%0d: got %b expected 1", c, bus.s_ready); else n_pass++;
      if (c >= 2 && c <= 7) begin
        n_checks++;
        if (bus.m_valid !== 1'b1 || observed() !== exp_r[c-2])
          $display("FAIL b2b_result_%0d: got v=%b %h expected v=1 %h", c - 2, bus.m_valid, observed(), exp_r[c-2]);
        else n_pass++;
        $display("tx b2b %0d: S=%h co=%b ovf=%b", c - 2, bus.S, bus.co, bus.ovf);
      end
      if (c == 8) begin
        n_checks++; if (bus.m_valid !== 1'b0) $display("FAIL b2b_drained: got %b expected 0", bus.m_valid); else n_pass++;
      end
    end
  endtask

  task automatic test_stall();
    int           sent = 0;
    int           got  = 0;
    logic [N-1:0] ca, cb;
    logic         cc;
    exp_q.delete();
    ca = N'($urandom()); cb = N'($urandom()); cc = 1'($urandom_range(0, 1));
    for (int c = 0; c < 20 && got < 4; c++) begin
      @(negedge clk);
      bus.m_ready = !(c >= 3 && c <= 5);
      bus.s_valid = (sent < 4);
      bus.A = ca; bus.B = cb; bus.ci = cc;
      #1;
      if (!bus.m_ready) begin
        n_checks++; if (bus.s_ready !== 1'b0) $display("FAIL stall_s_ready_%0d: got %b expected 0", c, bus.s_ready); else n_pass++;
        n_checks++;
        if (bus.m_valid !== 1'b1 || exp_q.size() == 0 || observed() !== exp_q[0])
          $display("FAIL stall_hold_%0d: got v=%b %h expected v=1 %h", c, bus.m_valid, observed(),
                   (exp_q.size() != 0) ? exp_q[0] : res_t'(0));
        else n_pass++;
      end
      if (bus.m_valid && bus.m_ready) begin
        res_t e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : res_t'(0);
        n_checks++;
        if (observed() !== e) $display("FAIL stall_result_%0d: got %h expected %h", got, observed(), e);
        else n_pass++;
        $display("tx stall %0d: S=%h co=%b ovf=%b", got, bus.S, bus.co, bus.ovf);
        got++;
      end
      if (bus.s_valid && bus.s_ready) begin
        exp_q.push_back(model(ca, cb, cc));
        sent++;
        ca = N'($urandom()); cb = N'($urandom()); cc = 1'($urandom_range(0, 1));
      end
    end
    n_checks++; if (got !== 4) $display("FAIL stall_count: got %0d results expected 4", got); else n_pass++;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_in_flight();
    @(negedge clk);
    bus.A = 8'h11; bus.B = 8'h22; bus.ci = 1'b0; bus.s_valid = 1'b1; bus.m_ready = 1'b0;
    @(negedge clk);
    bus.A = 8'h33; bus.B = 8'h44;
    @(negedge clk);
    bus.s_valid = 1'b0;
    rstn = 1'b0;
    #1;
    n_checks++; if (bus.m_valid !== 1'b0) $display("FAIL rstfl_m_valid: got %b expected 0", bus.m_valid); else n_pass++;
    n_checks++; if (bus.s_ready !== 1'b1) $display("FAIL rstfl_s_ready: got %b expected 1", bus.s_ready); else n_pass++;
    @(negedge clk);
    rstn = 1'b1;
    bus.m_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      n_checks++; if (bus.m_valid !== 1'b0) $display("FAIL rstfl_stale_%0d: got %b expected 0", c, bus.m_valid); else n_pass++;
    end
    @(negedge clk);
    bus.A = 8'd20; bus.B = 8'd22; bus.ci = 1'b1; bus.s_valid = 1'b1;
    @(negedge clk);
    bus.s_valid = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (bus.m_valid !== 1'b1 || observed() !== {2'b00, 8'd43})
      $display("FAIL rstfl_after: got v=%b %h expected v=1 %h", bus.m_valid, observed(), {2'b00, 8'd43});
    else n_pass++;
    $display("tx after reset: A=20 B=22 ci=1 -> S=%0d co=%b ovf=%b", bus.S, bus.co, bus.ovf);
  endtask

  task automatic test_random();
    int sent = 0;
    int got  = 0;
    exp_q.delete();
    for (int c = 0; c < 20000 && got < 1000; c++) begin
      @(negedge clk);
      bus.s_valid = (sent < 1000) && ($urandom_range(0, 9) < 7);
      bus.m_ready = ($urandom_range(0, 9) < 7) || (sent >= 1000);
      bus.A = N'($urandom()); bus.B = N'($urandom()); bus.ci = 1'($urandom_range(0, 1));
      #1;
      if (bus.m_valid && bus.m_ready) begin
        res_t e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : res_t'(0);
        n_checks++;
        if (observed() !== e) $display("FAIL random_%0d: got %h expected %h", got, observed(), e);
        else n_pass++;
        $display("tx random %0d: S=%h co=%b ovf=%b", got, bus.S, bus.co, bus.ovf);
        got++;
      end
      if (bus.s_valid && bus.s_ready) begin
        exp_q.push_back(model(bus.A, bus.B, bus.ci));
        sent++;
      end
    end
    n_checks++; if (got !== 1000) $display("FAIL random_count: got %0d results expected 1000", got); else n_pass++;
    n_checks++; if (exp_q.size() !== 0) $display("FAIL random_leftover: got %0d pending expected 0", exp_q.size()); else n_pass++;
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_latency();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_in_flight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
